// File: rtl/ro_buffer.sv
// Reorder buffer: in-order tag allocation, out-of-order write-back capture
// from the rs station and ls buffer buses, in-order retirement with register
// commit, store release and branch-mispredict flush.
module ro_buffer #(
  parameter int ROB_SIZE = 15,
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [1:0]          kind_from_issuer,
  input  logic [4:0]          rd_from_issuer,
  input  logic [XLEN-1:0]     pred_pc_from_issuer,
  output logic [ID_WIDTH-1:0] id_to_issuer,
  output logic                is_ro_buffer_full,
  input  logic [ID_WIDTH-1:0] query_j_id,
  input  logic [ID_WIDTH-1:0] query_k_id,
  output logic                ready_j,
  output logic                ready_k,
  output logic [XLEN-1:0]     value_j,
  output logic [XLEN-1:0]     value_k,
  input  logic [ID_WIDTH-1:0] dest_from_rss_bus,
  input  logic [XLEN-1:0]     value_from_rss_bus,
  input  logic [XLEN-1:0]     next_pc_from_rss_bus,
  input  logic [ID_WIDTH-1:0] dest_from_lsb_bus,
  input  logic [XLEN-1:0]     value_from_lsb_bus,
  output logic [4:0]          rd_to_reg_file,
  output logic [ID_WIDTH-1:0] id_to_reg_file,
  output logic [XLEN-1:0]     value_to_reg_file,
  output logic [ID_WIDTH-1:0] store_commit_to_lsb_bus,
  output logic                reset_to_rob_bus,
  output logic [XLEN-1:0]     target_pc_to_rob_bus
);

  // Storage is indexed directly by tag; slot 0 and slots above ROB_SIZE are
  // never allocated, so busy stays 0 there and any tag value is safe to use.
  localparam int DEPTH = 1 << ID_WIDTH;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  typedef struct packed {
    logic            ready;
    logic [XLEN-1:0] value;
  } query_t;

  logic [ID_WIDTH-1:0] head_q, tail_q, count_q;
  logic [DEPTH-1:0]    busy_q, ready_q;
  kind_e               kind_q    [DEPTH];
  logic [4:0]          rd_q      [DEPTH];
  logic [XLEN-1:0]     pred_pc_q [DEPTH];
  logic [XLEN-1:0]     actual_q  [DEPTH];
  logic [XLEN-1:0]     value_q   [DEPTH];

  logic   do_commit, mispredict, accept, do_alloc, rss_hit, lsb_hit;
  query_t qj, qk;

  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(ROB_SIZE)) ? ID_WIDTH'(1) : p + ID_WIDTH'(1);
  endfunction

  // Operand lookup: registered result first, then same-cycle bus forwarding
  // (rs station ahead of ls buffer). Only busy entries can answer.
  function automatic query_t lookup(input logic [ID_WIDTH-1:0] tag);
    query_t r;
    r = '0;
    if (tag != '0 && busy_q[tag]) begin
      if (ready_q[tag]) begin
        r.ready = 1'b1;
        r.value = value_q[tag];
      end else if (tag == dest_from_rss_bus) begin
        r.ready = 1'b1;
        r.value = value_from_rss_bus;
      end else if (tag == dest_from_lsb_bus) begin
        r.ready = 1'b1;
        r.value = value_from_lsb_bus;
      end
    end
    return r;
  endfunction

  // Cycle control decisions; the flush pulse blocks issue and bus capture.
  assign do_commit  = rdy && (count_q != '0) && ready_q[head_q];
  assign mispredict = do_commit && (kind_q[head_q] == KIND_BRANCH) &&
                      (actual_q[head_q] != pred_pc_q[head_q]);
  assign accept     = rdy && !reset_to_rob_bus;
  assign do_alloc   = accept && issue_valid;
  assign rss_hit    = accept && (dest_from_rss_bus != '0) && busy_q[dest_from_rss_bus];
  assign lsb_hit    = accept && (dest_from_lsb_bus != '0) && busy_q[dest_from_lsb_bus];

  assign id_to_issuer      = tail_q;
  assign is_ro_buffer_full = (count_q >= ID_WIDTH'(ROB_SIZE - 1));

  // Operand query ports for the issuer.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch can skip
    // it; a path that leaves a variable unassigned infers a latch.
    qj = lookup(query_j_id);
    qk = lookup(query_k_id);
  end

  assign ready_j = qj.ready;
  assign value_j = qj.value;
  assign ready_k = qk.ready;
  assign value_k = qk.value;

  // Pointers, occupancy, entry status bits and registered commit outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values; later assignments to the same bit take priority.
    if (rst) begin
      head_q                  <= ID_WIDTH'(1);
      tail_q                  <= ID_WIDTH'(1);
      count_q                 <= '0;
      busy_q                  <= '0;
      ready_q                 <= '0;
      rd_to_reg_file          <= '0;
      id_to_reg_file          <= '0;
      value_to_reg_file       <= '0;
      store_commit_to_lsb_bus <= '0;
      reset_to_rob_bus        <= 1'b0;
      target_pc_to_rob_bus    <= '0;
    end else if (rdy) begin
      rd_to_reg_file          <= '0;
      id_to_reg_file          <= '0;
      value_to_reg_file       <= '0;
      store_commit_to_lsb_bus <= '0;
      reset_to_rob_bus        <= 1'b0;
      target_pc_to_rob_bus    <= '0;
      if (do_commit) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= next_ptr(head_q);
        if (kind_q[head_q] == KIND_STORE) begin
          store_commit_to_lsb_bus <= head_q;
        end else begin
          rd_to_reg_file    <= rd_q[head_q];
          id_to_reg_file    <= head_q;
          value_to_reg_file <= value_q[head_q];
        end
        if (mispredict) begin
          reset_to_rob_bus     <= 1'b1;
          target_pc_to_rob_bus <= actual_q[head_q];
        end
      end
      if (rss_hit) ready_q[dest_from_rss_bus] <= 1'b1;
      if (lsb_hit) ready_q[dest_from_lsb_bus] <= 1'b1;
      // Allocation comes last so a full-queue alloc+commit on the same slot
      // leaves the new entry busy.
      if (do_alloc) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= next_ptr(tail_q);
      end
      count_q <= count_q + ID_WIDTH'(do_alloc) - ID_WIDTH'(do_commit);
      if (mispredict) begin
        head_q  <= ID_WIDTH'(1);
        tail_q  <= ID_WIDTH'(1);
        count_q <= '0;
        busy_q  <= '0;
        ready_q <= '0;
      end
    end
  end

  // Entry payload: written on allocation and on write-back.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are not reset; busy/ready gate every read, so
    // stale contents are never observed.
    if (do_alloc) begin
      kind_q[tail_q]    <= kind_e'(kind_from_issuer);
      rd_q[tail_q]      <= rd_from_issuer;
      pred_pc_q[tail_q] <= pred_pc_from_issuer;
    end
    if (rss_hit) begin
      value_q[dest_from_rss_bus]  <= value_from_rss_bus;
      actual_q[dest_from_rss_bus] <= next_pc_from_rss_bus;
    end
    if (lsb_hit) begin
      value_q[dest_from_lsb_bus] <= value_from_lsb_bus;
    end
  end

endmodule

// File: doc/ro_buffer.md
Name: ro_buffer

Overview:
- Reorder buffer at the receiving end of the rss bus and lsb bus; also the source of the rob bus reset.
- Allocates in-order tags (1..ROB_SIZE, 0 = "none") to the issuer and captures write-back results from the reservation station and the load/store buffer.
- Retires entries in program order: register writes go to the register file, stores are released to the ls buffer, and a branch mispredict broadcasts reset_to_rob_bus with a redirect PC.

Parameters:
ROB_SIZE, 15, number of entries; tags 1..ROB_SIZE, 0 reserved.
ID_WIDTH, 4, tag width; must satisfy 2^ID_WIDTH > ROB_SIZE.
XLEN, 32, data/PC width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = hold all state
issue_valid  in  1  issuer allocates an entry this cycle
kind_from_issuer  in  2  0=reg write, 1=branch/jump (also writes rd if rd!=0), 2=store
rd_from_issuer  in  5  architectural destination register
pred_pc_from_issuer  in  XLEN  predicted next PC (branch kind)
id_to_issuer  out  ID_WIDTH  tag the next allocation receives (= tail)
is_ro_buffer_full  out  1  pre-full flag
query_j_id, query_k_id  in  ID_WIDTH  operand tag lookups
ready_j, ready_k  out  1  combinational: value available for the queried tag
value_j, value_k  out  XLEN  combinational: value for the queried tag
dest_from_rss_bus  in  ID_WIDTH  rs station result tag (0 = none)
value_from_rss_bus  in  XLEN  rs station result
next_pc_from_rss_bus  in  XLEN  actual next PC
dest_from_lsb_bus  in  ID_WIDTH  ls buffer result tag (0 = none)
value_from_lsb_bus  in  XLEN  load result; store completion uses value 0
rd_to_reg_file  out  5  committed rd (0 = no write)
id_to_reg_file  out  ID_WIDTH  committed tag, for rename clear
value_to_reg_file  out  XLEN  committed value
store_commit_to_lsb_bus  out  ID_WIDTH  tag of committed store (0 = none)
reset_to_rob_bus  out  1  one-cycle flush pulse
target_pc_to_rob_bus  out  XLEN  redirect PC, valid while reset_to_rob_bus=1

Behaviour:
- Circular queue. head/tail range 1..ROB_SIZE; increment past ROB_SIZE wraps to 1. count is 0..ROB_SIZE.
- Reset: head=tail=1, count=0, all busy/ready=0.
- Reset, all outputs: every registered output is 0; id_to_issuer=1.
- rdy=0: no state or output changes.
- is_ro_buffer_full = (count >= ROB_SIZE-1). Pre-full, covering one in-flight issue.
- Allocation: on issue_valid, entry[tail] gets busy=1, ready=0, kind, rd, pred_pc; tail advances. The issuer must not assert issue_valid while the full flag is high; behaviour in that case is undefined.
- Write-back: when dest_from_rss_bus!=0 and that entry is busy, set ready=1, value, and actual_pc. The lsb bus does the same, storing value only. Tags of non-busy entries are ignored. Both buses may hit different tags in the same cycle.
- Query: ready_x=1 when the entry is busy&ready, or when the tag matches a nonzero rss/lsb bus tag this cycle (bus value forwarded; rss has priority). Tag 0 or non-busy gives ready_x=0, value_x=0.
- Commit: at most one entry per cycle. Condition: count>0 and entry[head] is ready; the ready bit must already be registered, so no same-cycle bypass.
- Commit outputs are registered, with one-cycle latency, and are zero in any cycle without a commit.
- Commit, kind 0: rd_to_reg_file=rd, id_to_reg_file=head, value_to_reg_file=value.
- Commit, kind 2: store_commit_to_lsb_bus=head; rd_to_reg_file=0.
- Commit, kind 1: register write as for kind 0. If actual_pc != pred_pc, then reset_to_rob_bus=1 and target_pc_to_rob_bus=actual_pc, and on that same edge the ROB flushes itself (head=tail=1, count=0, all busy=0).
- While reset_to_rob_bus=1: issue_valid and both bus inputs are ignored. The pulse drops the next cycle.
- count next = count + alloc - commit. Alloc and commit on the same cycle leave count unchanged, and this is legal when full.
- rst mid-operation overrides everything, including a pending commit or mispredict.

Test Plan:
1. Reset, then issue 3 kind-0 entries (rd=1,2,3). id_to_issuer steps 1,2,3,4. Write back tag 2 (0x22), then tag 1 (0x11). Commit order: tag1/x1=0x11 then tag2/x2=0x22. Tag 3 does not commit.
2. Issue ROB_SIZE-1=14 entries. is_ro_buffer_full rises at count=14. Commit 14 and refill so tail wraps 15→1. The next tag is 1 with no corruption.
3. Same-cycle write-back: rss tag 5 (0xAA) and lsb tag 6 (0xBB) together. Query_j=5 and query_k=6 in that cycle return ready=1 with 0xAA/0xBB via forwarding.
4. Branch tag 1 with pred_pc=0x100 and actual 0x200, followed by two younger entries. At commit: reset_to_rob_bus=1 for exactly one cycle, target=0x200. The younger entries never commit, and id_to_issuer returns to 1.
5. Store kind at head, ready via lsb (value 0): store_commit_to_lsb_bus=tag and rd_to_reg_file=0. Alloc and commit on the same cycle leave count unchanged.
6. Hold rdy=0 for 3 cycles during a pending commit: outputs and state frozen. The commit resumes on the first rdy=1 edge. Assert rst mid-stream: all outputs 0 and id_to_issuer=1.
